// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding, requester IDs,
// data width and the round-robin pick helper.
package mem_arb_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_IF_BUSY = 2'd1;
    localparam logic [1:0] ST_DM_BUSY = 2'd2;

    typedef enum logic {
        ARB_IF = 1'b0,
        ARB_DM = 1'b1
    } arb_id_e;

    // On a tie the requester that was not served last wins.
    function automatic arb_id_e arb_pick(input logic if_ok, input logic dm_ok, input arb_id_e last);
        if (if_ok && dm_ok) begin
            return (last == ARB_DM) ? ARB_IF : ARB_DM;
        end else if (dm_ok) begin
            return ARB_DM;
        end else begin
            return ARB_IF;
        end
    endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Access watchdog for mem_port_arbiter: down-counter loaded on grant, expires when the
// terminal count is reached during an access.
module arb_timeout_ctr #(
    parameter int CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int             W        = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0]   LOAD_VAL = W'(CYCLES - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (count && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // Expires in the last of CYCLES consecutive counted cycles.
    assign expire = count && (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Optional access timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 26,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IF_REQ,
    input  logic [ADDR_WIDTH-1:0] IF_ADDR,
    output logic                  IF_DONE,
    input  logic                  DM_REQ,
    input  logic                  DM_WE,
    input  logic [ADDR_WIDTH-1:0] DM_ADDR,
    input  logic [DATA_WIDTH-1:0] DM_WDATA,
    output logic                  DM_DONE,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    input  logic                  MEM_READY,
    output logic                  TIMEOUT_ERR
);

    // state      | meaning
    // ST_IDLE    | no access in flight; arbitrate pending requests
    // ST_IF_BUSY | instruction fetch read in progress
    // ST_DM_BUSY | data read or write in progress

    logic [1:0]            state_q;
    arb_id_e               last_q;
    arb_id_e               pick;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  if_done_q;
    logic                  dm_done_q;
    logic                  tout_q;
    logic                  if_ok;
    logic                  dm_ok;
    logic                  grant;
    logic                  busy;
    logic                  finish;
    logic                  abort;
    logic                  expire;

    assign busy   = (state_q == ST_IF_BUSY) || (state_q == ST_DM_BUSY);
    // A requester is not eligible in the cycle its DONE is showing.
    assign if_ok  = IF_REQ && !if_done_q;
    assign dm_ok  = DM_REQ && !dm_done_q;
    assign pick   = arb_pick(if_ok, dm_ok, last_q);
    assign grant  = (state_q == ST_IDLE) && (if_ok || dm_ok);
    assign finish = busy && MEM_READY;
    assign abort  = busy && !MEM_READY && expire;

`ifdef MEM_ARB_TIMEOUT_EN
    arb_timeout_ctr #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .CLK    (CLK),
        .RST    (RST),
        .load   (grant),
        .count  (busy),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            last_q    <= ARB_DM;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            tout_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        last_q <= pick;
                        if (pick == ARB_DM) begin
                            state_q <= ST_DM_BUSY;
                            addr_q  <= DM_ADDR;
                            we_q    <= DM_WE;
                            wdata_q <= DM_WDATA;
                        end else begin
                            state_q <= ST_IF_BUSY;
                            addr_q  <= IF_ADDR;
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                        end
                    end
                end
                ST_IF_BUSY, ST_DM_BUSY: begin
                    if (finish || abort) begin
                        state_q   <= ST_IDLE;
                        if_done_q <= (state_q == ST_IF_BUSY);
                        dm_done_q <= (state_q == ST_DM_BUSY);
                        tout_q    <= abort;
                        if (finish && !we_q) begin
                            rdata_q <= MEM_RDATA;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign MEM_READ    = busy && !we_q;
    assign MEM_WRITE   = (state_q == ST_DM_BUSY) && we_q;
    assign MEM_ADDR    = busy ? addr_q : '0;
    assign MEM_WDATA   = MEM_WRITE ? wdata_q : '0;
    assign RDATA       = rdata_q;
    assign IF_DONE     = if_done_q;
    assign DM_DONE     = dm_done_q;
    assign TIMEOUT_ERR = tout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int AW = 26;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, dm_req, dm_we, mem_ready;
    logic [AW-1:0] if_addr, dm_addr;
    logic [31:0]   dm_wdata, mem_rdata;
    logic          if_done, dm_done, mem_read, mem_write, tout_err;
    logic [31:0]   rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    mem_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .IF_REQ      (if_req),
        .IF_ADDR     (if_addr),
        .IF_DONE     (if_done),
        .DM_REQ      (dm_req),
        .DM_WE       (dm_we),
        .DM_ADDR     (dm_addr),
        .DM_WDATA    (dm_wdata),
        .DM_DONE     (dm_done),
        .RDATA       (rdata),
        .MEM_ADDR    (mem_addr),
        .MEM_READ    (mem_read),
        .MEM_WRITE   (mem_write),
        .MEM_WDATA   (mem_wdata),
        .MEM_RDATA   (mem_rdata),
        .MEM_READY   (mem_ready),
        .TIMEOUT_ERR (tout_err)
    );

    always #5 clk = ~clk;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    int n_asrt = 0;
    int n_fail = 0;

    // Reference model: owner 0 = none, 1 = fetch, 2 = data
    int            m_owner, m_last, m_cycles;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [31:0]   m_wdata, m_rdata;
    logic          m_if_done, m_dm_done, m_tout;

    int obs_rd, obs_wr, obs_ifd, obs_dmd, obs_to;
    int done_log[$];
    int got;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = 0;
        m_last    = 2;
        m_cycles  = 0;
        m_addr    = '0;
        m_we      = 1'b0;
        m_wdata   = '0;
        m_rdata   = '0;
        m_if_done = 1'b0;
        m_dm_done = 1'b0;
        m_tout    = 1'b0;
    endtask

    task automatic check_outputs();
        logic e_rd, e_wr;
        e_rd = (m_owner == 1) || (m_owner == 2 && !m_we);
        e_wr = (m_owner == 2) && m_we;
        chk("if_done",     32'(if_done),   32'(m_if_done));
        chk("dm_done",     32'(dm_done),   32'(m_dm_done));
        chk("timeout_err", 32'(tout_err),  32'(m_tout));
        chk("rdata",       rdata,          m_rdata);
        chk("mem_read",    32'(mem_read),  32'(e_rd));
        chk("mem_write",   32'(mem_write), 32'(e_wr));
        chk("mem_addr",    32'(mem_addr),  (m_owner != 0) ? 32'(m_addr) : 32'd0);
        chk("mem_wdata",   mem_wdata,      e_wr ? m_wdata : 32'd0);
        chk("both_strobes", 32'(mem_read & mem_write), 32'd0);
    endtask

    task automatic finish_owner();
        if (m_owner == 1) m_if_done = 1'b1;
        else              m_dm_done = 1'b1;
        m_owner = 0;
    endtask

    // Advance one clock: snapshot what the DUT samples, update the model, compare.
    task automatic tick();
        logic          s_if_req, s_dm_req, s_dm_we, s_ready, p_if, p_dm, if_ok, dm_ok;
        logic [AW-1:0] s_if_addr, s_dm_addr;
        logic [31:0]   s_wdata, s_rdata;
        s_if_req  = if_req;
        s_dm_req  = dm_req;
        s_dm_we   = dm_we;
        s_ready   = mem_ready;
        s_if_addr = if_addr;
        s_dm_addr = dm_addr;
        s_wdata   = dm_wdata;
        s_rdata   = mem_rdata;
        @(posedge clk);
        #1;
        if (!rst) begin
            model_reset();
        end else begin
            p_if = m_if_done;
            p_dm = m_dm_done;
            m_if_done = 1'b0;
            m_dm_done = 1'b0;
            m_tout    = 1'b0;
            if (m_owner != 0) begin
                m_cycles++;
                if (s_ready) begin
                    if (!m_we) m_rdata = s_rdata;
                    finish_owner();
                end else if (TO_EN && m_cycles >= TO) begin
                    m_tout = 1'b1;
                    finish_owner();
                end
            end else begin
                if_ok = s_if_req && !p_if;
                dm_ok = s_dm_req && !p_dm;
                if (if_ok && dm_ok) m_owner = (m_last == 2) ? 1 : 2;
                else if (if_ok)     m_owner = 1;
                else if (dm_ok)     m_owner = 2;
                if (m_owner == 1) begin
                    m_addr = s_if_addr; m_we = 1'b0; m_wdata = '0;
                end else if (m_owner == 2) begin
                    m_addr = s_dm_addr; m_we = s_dm_we; m_wdata = s_wdata;
                end
                if (m_owner != 0) begin
                    m_last   = m_owner;
                    m_cycles = 0;
                end
            end
        end
        check_outputs();
        if (mem_read)  obs_rd++;
        if (mem_write) obs_wr++;
        if (tout_err)  obs_to++;
        if (if_done) begin obs_ifd++; done_log.push_back(1); end
        if (dm_done) begin obs_dmd++; done_log.push_back(2); end
    endtask

    task automatic clear_obs();
        obs_rd = 0; obs_wr = 0; obs_ifd = 0; obs_dmd = 0; obs_to = 0;
        done_log.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        clear_obs();
        #1 rst = 1'b0;
        #1 model_reset();
        check_outputs();
        tick();
        tick();
        rst = 1'b1;

        // Both requesting for three rounds: IF wins first, then alternation
        clear_obs();
        if_addr = AW'(32'h100); dm_addr = AW'(32'h200); dm_we = 1'b0;
        if_req = 1; dm_req = 1;
        for (int i = 0; i < 20 && done_log.size() < 3; i++) begin
            mem_ready = (m_owner != 0);
            mem_rdata = 32'hA000_0000 + i;
            tick();
            if (done_log.size() == 3) begin if_req = 0; dm_req = 0; end
        end
        if_req = 0; dm_req = 0; mem_ready = 0;
        tick();
        chk("rr_round_count", 32'(done_log.size()), 32'd3);
        if (done_log.size() >= 3) begin
            chk("rr_round1", 32'(done_log[0]), 32'd1);
            chk("rr_round2", 32'(done_log[1]), 32'd2);
            chk("rr_round3", 32'(done_log[2]), 32'd1);
        end

        // Fetch with ready on the third strobe cycle
        clear_obs();
        if_addr = AW'(32'h10); if_req = 1;
        tick();
        tick();
        tick();
        mem_ready = 1; mem_rdata = 32'h2008_0005;
        tick();
        mem_ready = 0; if_req = 0;
        tick();
        chk("fetch_read_cycles", 32'(obs_rd), 32'd3);
        chk("fetch_done_pulses", 32'(obs_ifd), 32'd1);
        chk("fetch_rdata", rdata, 32'h2008_0005);

        // Data write; later input changes must not leak into the access
        clear_obs();
        dm_req = 1; dm_we = 1; dm_addr = AW'(32'h3FF); dm_wdata = 32'hDEAD_BEEF;
        tick();
        dm_wdata = 32'h1234_5678; dm_addr = AW'(32'h3); dm_we = 0;
        chk("write_strobe", 32'(mem_write), 32'd1);
        chk("write_addr", 32'(mem_addr), 32'h3FF);
        tick();
        chk("write_data_held", mem_wdata, 32'hDEAD_BEEF);
        mem_ready = 1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ready = 0; dm_req = 0;
        tick();
        chk("write_done_pulses", 32'(obs_dmd), 32'd1);
        chk("write_rdata_kept", rdata, 32'h2008_0005);

        // Requester held high through its DONE cycle: one idle turnaround cycle
        if_addr = AW'(32'h44); if_req = 1;
        tick();
        mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ready = 0;
        tick();
        chk("turnaround_idle", 32'(mem_read), 32'd0);
        tick();
        chk("turnaround_regrant", 32'(mem_read), 32'd1);
        mem_ready = 1; mem_rdata = 32'h0000_0044;
        tick();
        if_req = 0; mem_ready = 0;
        tick();

        // Memory never answers
        clear_obs();
        if_addr = AW'(32'h2A); if_req = 1; mem_ready = 0; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_if_done) if_req = 0;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        chk("timeout_strobe_cycles", 32'(obs_rd), 32'd4);
        chk("timeout_err_pulses", 32'(obs_to), 32'd1);
        chk("timeout_done_pulses", 32'(obs_ifd), 32'd1);
`else
        chk("notimeout_strobe_cycles", 32'(obs_rd), 32'd10);
        chk("notimeout_err_pulses", 32'(obs_to), 32'd0);
        chk("notimeout_done_pulses", 32'(obs_ifd), 32'd0);
        mem_ready = 1; mem_rdata = 32'h0000_002A;
        tick();
        mem_ready = 0; if_req = 0;
        tick();
        chk("notimeout_late_done", 32'(obs_ifd), 32'd1);
`endif
        if_req = 0;
        tick();

        // Reset in the middle of a data read, then re-request
        clear_obs();
        dm_req = 1; dm_we = 0; dm_addr = AW'(32'h155); mem_ready = 0;
        tick();
        chk("reset_read_busy", 32'(mem_read), 32'd1);
        #2 rst = 1'b0;
        #1 model_reset();
        check_outputs();
        chk("reset_read_dropped", 32'(mem_read), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            mem_ready = (m_owner != 0);
            mem_rdata = 32'hC0DE_0155;
            tick();
            if (m_dm_done) begin got = 1; dm_req = 0; end
        end
        mem_ready = 0; dm_req = 0;
        tick();
        chk("reset_rerequest_done", 32'(got), 32'd1);
        chk("reset_done_pulses", 32'(obs_dmd), 32'd1);
        chk("reset_rerequest_rdata", rdata, 32'hC0DE_0155);

        // Randomized traffic with random memory latency and stray READY pulses
        for (int c = 0; c < 800; c++) begin
            if (m_if_done) begin
                if ($urandom_range(0, 1) == 0) if_req = 0;
            end else if (!if_req) begin
                if ($urandom_range(0, 3) == 0) if_req = 1;
            end else if ($urandom_range(0, 39) == 0) begin
                if_req = 0;
            end
            if (m_dm_done) begin
                if ($urandom_range(0, 1) == 0) dm_req = 0;
            end else if (!dm_req) begin
                if ($urandom_range(0, 3) == 0) dm_req = 1;
            end else if ($urandom_range(0, 39) == 0) begin
                dm_req = 0;
            end
            if_addr   = AW'($urandom);
            dm_addr   = AW'($urandom);
            dm_we     = 1'($urandom);
            dm_wdata  = $urandom;
            mem_rdata = $urandom;
            mem_ready = (m_owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 26, memory word-address width; data width fixed at 32.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, access-cycle limit before abort (used only with MEM_ARB_TIMEOUT_EN).
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 IF_REQ  input  1  instruction-fetch read request, held high until IF_DONE.
REQ-006 IF_ADDR  input  ADDR_WIDTH  fetch address.
REQ-007 IF_DONE  output  1  one-cycle pulse, fetch complete, RDATA valid.
REQ-008 DM_REQ  input  1  data access request (lw/sw/push/pop), held high until DM_DONE.
REQ-009 DM_WE  input  1  1 = write, 0 = read.
REQ-010 DM_ADDR  input  ADDR_WIDTH  data address.
REQ-011 DM_WDATA  input  32  store data.
REQ-012 DM_DONE  output  1  one-cycle pulse, data access complete.
REQ-013 RDATA  output  32  read data, valid with IF_DONE or DM_DONE (read).
REQ-014 MEM_ADDR  output  ADDR_WIDTH  memory address.
REQ-015 MEM_READ  output  1  memory read strobe.
REQ-016 MEM_WRITE  output  1  memory write strobe.
REQ-017 MEM_WDATA  output  32  memory write data.
REQ-018 MEM_RDATA  input  32  memory read data.
REQ-019 MEM_READY  input  1  memory access complete, one cycle.
REQ-020 TIMEOUT_ERR  output  1  one-cycle pulse with DONE when an access aborted.

Function
REQ-021 FSM states IDLE, IF_BUSY, DM_BUSY; exactly one state active.
REQ-022 IDLE: single requester -> its BUSY state next edge; both requesting -> requester not served last wins (round-robin, initial last-served = DM, so IF wins first).
REQ-023 On grant edge, address, DM_WE and DM_WDATA shall be registered; later input changes ignored until DONE.
REQ-024 BUSY: MEM_READ (IF, or DM with WE=0) or MEM_WRITE (DM with WE=1) held high every cycle; never both high; both low in IDLE.
REQ-025 MEM_WDATA = registered DM_WDATA during DM write, else 0; MEM_ADDR = registered address during BUSY, else 0.
REQ-026 MEM_READY high in BUSY -> RDATA captures MEM_RDATA (reads only), FSM -> IDLE, matching DONE pulses the following cycle.
REQ-027 Minimum latency: REQ high at edge 0, strobe at edge 1, MEM_READY same cycle, DONE at edge 2.
REQ-028 During the DONE cycle, that requester's REQ shall be ignored (one-cycle turnaround); the other requester may be granted.
REQ-029 MEM_READY in IDLE shall be ignored; REQ dropped mid-access: access completes, DONE still pulses.
REQ-030 RDATA holds last captured value until next read completes; writes leave it unchanged.

Reset
REQ-031 RST low: FSM -> IDLE, last-served = DM, all outputs 0, immediately without clock.
REQ-032 Reset mid-access: strobes drop at once, no DONE issued; requester re-requests after release.

Configuration
REQ-033 MEM_ARB_TIMEOUT_EN defined: BUSY cycle counter; TIMEOUT_CYCLES consecutive BUSY cycles without MEM_READY -> strobes drop, IDLE, DONE and TIMEOUT_ERR pulse together, RDATA unchanged.
REQ-034 MEM_ARB_TIMEOUT_EN undefined: no counter, BUSY waits indefinitely, TIMEOUT_ERR tied 0.

Structure
REQ-035 Shared package mem_arb_pkg: FSM state encoding, requester IDs (ARB_IF, ARB_DM), DATA_WIDTH constant 32.
REQ-036 One sub-module arb_timeout_ctr (load/count/expire), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-037 IF_REQ, IF_ADDR=0x10, MEM_READY 3 cycles later with MEM_RDATA=0x20080005 -> MEM_READ 3 cycles, IF_DONE one cycle, RDATA=0x20080005.
REQ-038 DM_REQ, DM_WE=1, DM_ADDR=0x3FF, DM_WDATA=0xDEADBEEF -> MEM_WRITE high, MEM_WDATA=0xDEADBEEF until READY, DM_DONE, RDATA unchanged.
REQ-039 IF_REQ and DM_REQ together, both held three rounds -> grants IF, DM, IF; never both strobes high.
REQ-040 RST low during DM read BUSY -> MEM_READ 0 immediately, no DM_DONE; after release re-request completes normally.
REQ-041 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, MEM_READY never -> strobe 4 cycles, then DONE and TIMEOUT_ERR one cycle; undefined build -> strobe stays high.
